// File: rtl/tx_frame_sched.sv
// Transmit frame scheduler: arbitrates alarm, TCM and periodic status frames,
// hands a one-cycle start to the return-path mux and paces frames with an IFG.
module tx_frame_sched #(
  parameter int RPT_PERIOD = 25000000,
  parameter int IFG_CYCLES = 24,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 16
) (
  input  logic             tx_clk,
  input  logic             rst_n,
  input  logic             link_on,
  input  logic             alarm_in,
  input  logic             tcm_rdy,
  input  logic             tx_done,
  output logic             start,
  output logic [1:0]       frame_type,
  output logic             busy,
  output logic             tcm_ack,
  output logic             timeout_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int TMR_W = (RPT_PERIOD > 2) ? $clog2(RPT_PERIOD) : 1;
  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RPT_PERIOD - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);

  localparam logic [1:0] FT_NONE   = 2'b00;
  localparam logic [1:0] FT_STATUS = 2'b01;
  localparam logic [1:0] FT_TCM    = 2'b10;
  localparam logic [1:0] FT_ALARM  = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_alm_d;
  logic             r_alm_pend;
  logic             r_rpt_pend;
  logic [TMR_W-1:0] r_rpt_tmr;
  logic [WD_W-1:0]  r_wd;
  logic [GAP_W-1:0] r_gap;
  logic             r_start;
  logic [1:0]       r_frame_type;
  logic             r_busy;
  logic             r_tcm_ack;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_frame_cnt;

  logic w_alm_rise;
  logic w_rpt_set;
  logic w_grant;
  logic w_abort;
  logic w_alm_clr;
  logic w_rpt_clr;

  assign w_alm_rise = alarm_in & ~r_alm_d;
  assign w_rpt_set  = link_on & (r_rpt_tmr == TMR_LAST);
  assign w_grant    = (r_state == IDLE) & link_on & (r_alm_pend | tcm_rdy | r_rpt_pend);
  assign w_abort    = ((r_state == START) | (r_state == WAIT_DONE)) & ~link_on;

  // A flag is cleared only when its own source wins arbitration, or on abort.
  assign w_alm_clr  = w_abort | (w_grant & r_alm_pend);
  assign w_rpt_clr  = w_abort | (w_grant & ~r_alm_pend & ~tcm_rdy & r_rpt_pend);

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alm_d    <= 1'b0;
      r_alm_pend <= 1'b0;
      r_rpt_pend <= 1'b0;
      r_rpt_tmr  <= '0;
    end else begin
      r_alm_d    <= alarm_in;
      r_alm_pend <= w_alm_rise | (r_alm_pend & ~w_alm_clr);
      r_rpt_pend <= w_rpt_set  | (r_rpt_pend & ~w_rpt_clr);
      if (!link_on || (r_rpt_tmr == TMR_LAST)) begin
        r_rpt_tmr <= '0;
      end else begin
        r_rpt_tmr <= r_rpt_tmr + TMR_W'(1);
      end
    end
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_wd          <= '0;
      r_gap         <= '0;
      r_start       <= 1'b0;
      r_frame_type  <= FT_NONE;
      r_busy        <= 1'b0;
      r_tcm_ack     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_start       <= 1'b0;
      r_tcm_ack     <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state <= START;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            if (r_alm_pend) begin
              r_frame_type <= FT_ALARM;
            end else if (tcm_rdy) begin
              r_frame_type <= FT_TCM;
            end else begin
              r_frame_type <= FT_STATUS;
            end
          end
        end
        START: begin
          if (!link_on) begin
            r_state      <= IDLE;
            r_frame_type <= FT_NONE;
            r_busy       <= 1'b0;
          end else begin
            r_state <= WAIT_DONE;
            r_wd    <= '0;
          end
        end
        WAIT_DONE: begin
          // Link loss outranks a coincident tx_done; tx_done outranks the watchdog.
          if (!link_on) begin
            r_state      <= IDLE;
            r_frame_type <= FT_NONE;
            r_busy       <= 1'b0;
          end else if (tx_done) begin
            r_frame_cnt  <= r_frame_cnt + CNT_W'(1);
            r_tcm_ack    <= (r_frame_type == FT_TCM);
            r_state      <= GAP;
            r_frame_type <= FT_NONE;
            r_gap        <= '0;
          end else if (r_wd == WD_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= GAP;
            r_frame_type  <= FT_NONE;
            r_gap         <= '0;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        GAP: begin
          if (r_gap == GAP_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign start       = r_start;
  assign frame_type  = r_frame_type;
  assign busy        = r_busy;
  assign tcm_ack     = r_tcm_ack;
  assign timeout_err = r_timeout_err;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Scoreboard bench for tx_frame_sched: expected start/tcm_ack/timeout_err events
// with their cycle and frame_cnt are queued by the driver and popped by a monitor.
module tb_tx_frame_sched;

  localparam int RPT_PERIOD = 100;
  localparam int IFG_CYCLES = 24;
  localparam int TIMEOUT    = 64;
  localparam int CNT_W      = 4;

  localparam int EV_START = 0;
  localparam int EV_ACK   = 1;
  localparam int EV_TMO   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             link_on = 1'b0;
  logic             alarm_in = 1'b0;
  logic             tcm_rdy = 1'b0;
  logic             tx_done = 1'b0;
  logic             start;
  logic [1:0]       frame_type;
  logic             busy;
  logic             tcm_ack;
  logic             timeout_err;
  logic [CNT_W-1:0] frame_cnt;

  typedef struct {
    int kind;
    int val;
    int cnt;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  tx_frame_sched #(
    .RPT_PERIOD(RPT_PERIOD),
    .IFG_CYCLES(IFG_CYCLES),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .tx_clk     (clk),
    .rst_n      (rst_n),
    .link_on    (link_on),
    .alarm_in   (alarm_in),
    .tcm_rdy    (tcm_rdy),
    .tx_done    (tx_done),
    .start      (start),
    .frame_type (frame_type),
    .busy       (busy),
    .tcm_ack    (tcm_ack),
    .timeout_err(timeout_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "bench time limit expired");
  end

  task automatic push_exp(input int kind, input int val, input int cnt, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cnt  = cnt;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic mon_check(input int kind);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind=%0d at cyc=%0d type=%0d cnt=%0d, none expected",
               kind, cyc, frame_type, frame_cnt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.cnt != int'(frame_cnt) ||
          (kind == EV_START && e.val != int'(frame_type))) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cyc=%0d type=%0d cnt=%0d, expected kind=%0d cyc=%0d type=%0d cnt=%0d",
                 kind, cyc, frame_type, frame_cnt, e.kind, e.cyc, e.val, e.cnt);
      end
    end
  endtask

  always @(negedge clk) begin
    if (start)       mon_check(EV_START);
    if (tcm_ack)     mon_check(EV_ACK);
    if (timeout_err) mon_check(EV_TMO);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_done_at(input int c);
    wait_to(c);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic end_test(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset(output int c0);
    @(negedge clk);
    rst_n    = 1'b0;
    link_on  = 1'b0;
    alarm_in = 1'b0;
    tcm_rdy  = 1'b0;
    tx_done  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c0    = cyc;
  endtask

  initial begin
    int c0, s1, s2, s3, s4, l;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_frame_type", frame_type, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tcm_ack", tcm_ack, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    // periodic status report only
    do_reset(c0);
    link_on = 1'b1;
    s1 = c0 + 101;
    s2 = c0 + 201;
    push_exp(EV_START, 1, 0, s1);
    push_exp(EV_START, 1, 1, s2);
    wait_to(s1);
    chk("t1_busy_start", busy, 1);
    pulse_done_at(s1 + 10);
    wait_to(s1 + 12);
    chk("t1_cnt", frame_cnt, 1);
    chk("t1_gap_type", frame_type, 0);
    chk("t1_gap_busy", busy, 1);
    wait_to(s1 + 34);
    chk("t1_gap_last_busy", busy, 1);
    wait_to(s1 + 35);
    chk("t1_idle_busy", busy, 0);
    wait_to(s2 + 2);
    end_test("t1_queue");

    // alarm, tcm and status pending together
    do_reset(c0);
    link_on = 1'b1;
    s1 = c0 + 101;
    s2 = s1 + 31;
    s3 = s2 + 31;
    push_exp(EV_START, 3, 0, s1);
    push_exp(EV_START, 2, 1, s2);
    push_exp(EV_ACK,   0, 2, s2 + 6);
    push_exp(EV_START, 1, 2, s3);
    wait_to(c0 + 99);
    alarm_in = 1'b1;
    wait_to(c0 + 100);
    tcm_rdy = 1'b1;
    pulse_done_at(s1 + 5);
    wait_to(s2);
    tcm_rdy  = 1'b0;
    alarm_in = 1'b0;
    pulse_done_at(s2 + 5);
    pulse_done_at(s3 + 5);
    wait_to(s3 + 8);
    chk("t2_cnt", frame_cnt, 3);
    end_test("t2_queue");

    // watchdog timeout and tcm retry
    do_reset(c0);
    link_on = 1'b1;
    tcm_rdy = 1'b1;
    s1 = c0 + 1;
    s2 = s1 + 90;
    push_exp(EV_START, 2, 0, s1);
    push_exp(EV_TMO,   0, 0, s1 + 65);
    push_exp(EV_START, 2, 0, s2);
    push_exp(EV_ACK,   0, 1, s2 + 4);
    wait_to(s1 + 66);
    chk("t3_cnt_after_tmo", frame_cnt, 0);
    wait_to(s2);
    tcm_rdy = 1'b0;
    pulse_done_at(s2 + 3);
    wait_to(s2 + 7);
    end_test("t3_queue");

    // link loss in WAIT_DONE; alarm captured while link is down
    do_reset(c0);
    link_on = 1'b1;
    tcm_rdy = 1'b1;
    s1 = c0 + 1;
    push_exp(EV_START, 2, 0, s1);
    wait_to(s1 + 5);
    link_on = 1'b0;
    wait_to(s1 + 6);
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_type", frame_type, 0);
    pulse_done_at(s1 + 8);
    wait_to(s1 + 10);
    chk("t4_cnt_stray_done", frame_cnt, 0);
    wait_to(s1 + 20);
    alarm_in = 1'b1;
    l = s1 + 150;
    push_exp(EV_START, 3, 0, l + 1);
    push_exp(EV_START, 1, 1, l + 101);
    wait_to(l);
    tcm_rdy = 1'b0;
    link_on = 1'b1;
    pulse_done_at(l + 3);
    wait_to(l + 5);
    chk("t4_cnt", frame_cnt, 1);
    wait_to(l + 103);
    end_test("t4_queue");

    // alarm edge on grant cycle; tx_done on watchdog terminal
    do_reset(c0);
    link_on = 1'b1;
    tcm_rdy = 1'b1;
    s1 = c0 + 1;
    s2 = s1 + 30;
    s3 = s2 + 90;
    s4 = s3 + 28;
    push_exp(EV_START, 2, 0, s1);
    push_exp(EV_ACK,   0, 1, s1 + 5);
    push_exp(EV_START, 3, 1, s2);
    push_exp(EV_START, 3, 2, s3);
    push_exp(EV_START, 1, 3, s4);
    wait_to(s1);
    tcm_rdy = 1'b0;
    wait_to(s1 + 2);
    alarm_in = 1'b1;
    wait_to(s1 + 3);
    alarm_in = 1'b0;
    pulse_done_at(s1 + 4);
    wait_to(s2 - 1);
    alarm_in = 1'b1;
    wait_to(s2 + 1);
    alarm_in = 1'b0;
    pulse_done_at(s2 + 64);
    wait_to(s2 + 66);
    chk("t5_cnt_terminal", frame_cnt, 2);
    pulse_done_at(s3 + 2);
    wait_to(s4 + 2);
    end_test("t5_queue");

    // frame_cnt wrap with back-to-back tcm frames
    do_reset(c0);
    link_on = 1'b1;
    tcm_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_exp(EV_START, 2, i % 16, c0 + 1 + 27 * i);
      push_exp(EV_ACK,   0, (i + 1) % 16, c0 + 3 + 27 * i);
    end
    for (int i = 0; i < 16; i++) begin
      pulse_done_at(c0 + 2 + 27 * i);
    end
    wait_to(c0 + 1 + 27 * 15 + 4);
    tcm_rdy = 1'b0;
    chk("t6_cnt_wrap", frame_cnt, 0);
    end_test("t6_queue");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
